// File: rtl/exp_calculator_vec.sv
// N-lane pipelined Q4.12 exp(x), 3-cycle latency, one vector per clock, no backpressure.
// Optional macro EXP_CALC_POS_SAT_EN: compute positive inputs with saturation instead of clamping them to 0.
module exp_calculator_vec #(
    parameter int N         = 4,
    parameter int BIT_WIDTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    input  logic signed [BIT_WIDTH-1:0] i_data [N],
    output logic signed [BIT_WIDTH-1:0] o_exp  [N],
    output logic                        o_valid
);
    localparam int FRAC = 12;
    localparam int YF   = 2 * FRAC;
    localparam int PW   = BIT_WIDTH + 14;
    localparam int KW   = PW - YF;
    localparam int SW   = KW + 1;
    localparam logic signed [PW-1:0] LOG2E = PW'(5909);
`ifdef EXP_CALC_POS_SAT_EN
    localparam logic [17:0] SAT = 18'((1 << (BIT_WIDTH - 1)) - 1);
`endif

    // 2^(idx/64) in Q1.15, built by repeated multiplication by 2^(1/64) held in Q2.30.
    function automatic logic [16:0] exp2_q15(input int idx);
        logic [63:0] acc;
        acc = 64'd1 << 30;
        for (int j = 0; j < idx; j++)
            acc = (acc * 64'd1085434106 + (64'd1 << 29)) >> 30;
        return 17'((acc + (64'd1 << 14)) >> 15);
    endfunction

    logic [16:0] lut [65];
    for (genvar g = 0; g < 65; g++) begin : g_lut
        localparam logic [16:0] ENTRY = exp2_q15(g);
        assign lut[g] = ENTRY;
    end

    logic [2:0] vld;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            vld     <= '0;
            o_valid <= 1'b0;
        end else begin
            vld     <= {vld[1:0], i_valid};
            o_valid <= vld[2];
        end
    end

    for (genvar l = 0; l < N; l++) begin : g_lane
        logic signed [BIT_WIDTH-1:0] x_q;
        logic signed [BIT_WIDTH-1:0] x_c;
        logic signed [PW-1:0]        prod;
        logic signed [KW-1:0]        k1;
        logic signed [KW-1:0]        k2;
        logic [YF-1:0]               f1;
        logic [16:0]                 lo;
        logic [16:0]                 hi;
        logic [16:0]                 p_c;
        logic [16:0]                 p2;
        logic signed [SW-1:0]        sh;
        logic [4:0]                  sa;
        logic [17:0]                 rnd;
        logic [BIT_WIDTH-1:0]        res_c;
        logic [BIT_WIDTH-1:0]        res_q;

`ifdef EXP_CALC_POS_SAT_EN
        assign x_c = x_q;
`else
        assign x_c = (x_q > 0) ? '0 : x_q;
`endif
        // y = x*log2(e) in Q.24: integer part is k, low 24 bits are f.
        assign prod = PW'(x_c) * LOG2E;

        assign lo  = lut[{1'b0, f1[YF-1:YF-6]}];
        assign hi  = lut[{1'b0, f1[YF-1:YF-6]} + 7'd1];
        assign p_c = lo + 17'((35'(hi - lo) * 35'(f1[YF-7:0])) >> 18);

        // Q1.15 to Q.12 is a right shift by 3, so 2^k folds into a shift of 3-k.
        assign sh = SW'(3) - SW'(k2);
        assign sa = sh[4:0];

        always_comb begin
            rnd   = ({1'b0, p2} + (18'd1 << (sa - 5'd1))) >> sa;
            res_c = BIT_WIDTH'(rnd);
            if (sh > SW'(16))
                res_c = '0;
`ifdef EXP_CALC_POS_SAT_EN
            else if (sh < SW'(1) || rnd > SAT)
                res_c = SAT[BIT_WIDTH-1:0];
`endif
        end

        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                x_q   <= '0;
                k1    <= '0;
                f1    <= '0;
                k2    <= '0;
                p2    <= '0;
                res_q <= '0;
            end else begin
                if (i_valid)
                    x_q <= i_data[l];
                if (vld[0]) begin
                    k1 <= prod[PW-1:YF];
                    f1 <= prod[YF-1:0];
                end
                if (vld[1]) begin
                    k2 <= k1;
                    p2 <= p_c;
                end
                if (vld[2])
                    res_q <= res_c;
            end
        end

        assign o_exp[l] = res_q;
    end
endmodule

// File: tb/tb_exp_calculator_vec.sv
// Bench for exp_calculator_vec: real-arithmetic exp model with a latency queue, plus literal vectors.
module tb_exp_calculator_vec;
    localparam int N  = 4;
    localparam int BW = 16;

    typedef int vec_t [N];
    typedef struct {
        int   due;
        vec_t x;
        vec_t lit;
        bit   has_lit;
    } pend_t;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 vld   = 1'b0;
    logic signed [BW-1:0] din  [N];
    logic signed [BW-1:0] dout [N];
    logic                 ovld;

    vec_t  cur_lit;
    bit    cur_has = 1'b0;
    int    errors  = 0;
    int    checks  = 0;
    int    cyc     = 0;
    int    pulses  = 0;
    pend_t q[$];
    vec_t  last;

    always #5 clk = ~clk;

    exp_calculator_vec #(.N(N), .BIT_WIDTH(BW)) dut (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .i_valid(vld),
        .i_data (din),
        .o_exp  (dout),
        .o_valid(ovld)
    );

    function automatic int ref_exp(input int x);
        real r;
        if (x > 0) begin
`ifdef EXP_CALC_POS_SAT_EN
            if (x >= 8518) return 32767;
`else
            return 4096;
`endif
        end
        r = $exp(real'(x) / 4096.0) * 4096.0;
        return int'($floor(r + 0.5));
    endfunction

    task automatic chk(input string name, input int act, input int req, input int tol);
        checks++;
        if (act < req - tol || act > req + tol) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (+/-%0d) at cycle %0d", name, act, req, tol, cyc);
        end
    endtask

    // Inputs are captured on rising edges; outputs are judged on falling edges.
    always @(clk) begin : model
        pend_t e;
        bit    due_now;
        if (clk) begin
            cyc++;
            if (rst_n && vld) begin
                e.due = cyc + 3;
                for (int l = 0; l < N; l++) e.x[l] = int'(din[l]);
                e.lit     = cur_lit;
                e.has_lit = cur_has;
                q.push_back(e);
            end
        end else begin
            if (!rst_n) begin
                q.delete();
                for (int l = 0; l < N; l++) last[l] = 0;
            end
            due_now = (q.size() > 0) && (q[0].due == cyc);
            chk("o_valid", int'(ovld), int'(due_now), 0);
            if (due_now) begin
                e = q.pop_front();
                pulses++;
                for (int l = 0; l < N; l++) begin
                    chk($sformatf("exp_model[%0d] x=%0d", l, e.x[l]), int'(dout[l]), ref_exp(e.x[l]), 1);
                    chk($sformatf("exp_nonneg[%0d]", l), int'(dout[l] < 0), 0, 0);
                    if (e.has_lit)
                        chk($sformatf("exp_literal[%0d] x=%0d", l, e.x[l]), int'(dout[l]), e.lit[l], 1);
                    if (e.x[l] == 0)
                        chk($sformatf("exp_zero[%0d]", l), int'(dout[l]), 4096, 0);
                    last[l] = int'(dout[l]);
                end
            end else begin
                for (int l = 0; l < N; l++)
                    chk($sformatf("hold[%0d]", l), int'(dout[l]), last[l], 0);
            end
        end
    end

    task automatic set_vec(input vec_t xs, input vec_t lit, input bit has);
        vld = 1'b1;
        for (int l = 0; l < N; l++) din[l] = BW'(xs[l]);
        cur_lit = lit;
        cur_has = has;
    endtask

    task automatic drive(input vec_t xs, input vec_t lit, input bit has);
        @(posedge clk);
        #2;
        set_vec(xs, lit, has);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            vld     = 1'b0;
            cur_has = 1'b0;
        end
    endtask

    initial begin
        vec_t pos_lit;
        vec_t xs;
        vec_t none;
        none = '{0, 0, 0, 0};
`ifdef EXP_CALC_POS_SAT_EN
        pos_lit = '{11134, 32767, 32767, 4097};
`else
        pos_lit = '{4096, 4096, 4096, 4096};
`endif
        for (int l = 0; l < N; l++) din[l] = '0;

        // Reset held for two edges with a valid vector presented; it is first taken after release.
        #1;
        rst_n = 1'b0;
        set_vec('{-3872, -1379, 0, -722}, '{1591, 2925, 4096, 3434}, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        drive('{-4321, 0, -5080, -3567}, '{1426, 4096, 1185, 1715}, 1'b1);
        idle(5);

        drive('{-32768, -1, -12288, -4096}, '{1, 4096, 204, 1507}, 1'b1);
        idle(5);

        drive('{-2048, -1024, -512, -256}, none, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        vld   = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(4);

        drive('{4096, 8518, 32767, 1}, pos_lit, 1'b1);
        idle(5);

        for (int i = 0; i < 12; i++) begin
            for (int l = 0; l < N; l++) xs[l] = -(i * 2731) - (l * 683);
            drive(xs, none, 1'b0);
        end
        idle(6);

        chk("queue_drained", q.size(), 0, 0);
        chk("valid_pulses", pulses, 16, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
